// File: rtl/servo_pkg.sv
// Shared constants, pulse-width word type and clamp helper for the servo PWM bank.
package servo_pkg;

    localparam int unsigned US_PER_S     = 1_000_000;
    localparam int unsigned CLK_HZ_DEF   = 100_000_000;
    localparam int unsigned FRAME_US_DEF = 20000;
    localparam int unsigned MIN_US_DEF   = 1000;
    localparam int unsigned MAX_US_DEF   = 2000;

    // Wide enough to hold any command width without loss before clamping.
    typedef logic [31:0] us_word_t;

    function automatic us_word_t clamp_us(input us_word_t us, input us_word_t lo, input us_word_t hi);
        if (us < lo) begin
            return lo;
        end
        if (us > hi) begin
            return hi;
        end
        return us;
    endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// Command port of the servo PWM bank: the controller writes one channel width per transfer.
// A transfer happens on a rising clk edge where cmd_valid && cmd_ready; the master holds
// cmd_valid, cmd_ch and cmd_us stable until then, and cmd_ready never depends on cmd_valid.
interface servo_pwm_bank_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned W      = 16
);
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [CHW-1:0] cmd_ch;
    logic [W-1:0]   cmd_us;

    modport master (output cmd_valid, output cmd_ch, output cmd_us, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_ch, input cmd_us, output cmd_ready);

endinterface

// File: rtl/servo_timebase.sv
// Microsecond prescaler and frame counter; flags the last clock of every frame.
module servo_timebase import servo_pkg::*; #(
    parameter int unsigned CLK_HZ   = CLK_HZ_DEF,
    parameter int unsigned FRAME_US = FRAME_US_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [$clog2(FRAME_US)-1:0] us_cnt,
    output logic                        us_tick,
    output logic                        boundary
);
    localparam int unsigned DIV = CLK_HZ / US_PER_S;
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned UCW = $clog2(FRAME_US);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [UCW-1:0] US_LAST  = UCW'(FRAME_US - 1);

    logic [DW-1:0]  div_cnt_q, div_cnt_d;
    logic [UCW-1:0] us_cnt_q, us_cnt_d;

    always_comb begin
        us_tick  = (div_cnt_q == DIV_LAST);
        boundary = us_tick && (us_cnt_q == US_LAST);
        div_cnt_d = us_tick ? '0 : div_cnt_q + 1'b1;
        us_cnt_d  = us_cnt_q;
        if (us_tick) begin
            us_cnt_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            us_cnt_q  <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            us_cnt_q  <= us_cnt_d;
        end
    end

    assign us_cnt = us_cnt_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel frame-synchronous servo pulse generator with shadowed width registers,
// clamped command writes and an enable that is only sampled at frame boundaries.
module servo_pwm_bank import servo_pkg::*; #(
    parameter int unsigned CLK_HZ   = CLK_HZ_DEF,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned FRAME_US = FRAME_US_DEF,
    parameter int unsigned MIN_US   = MIN_US_DEF,
    parameter int unsigned MAX_US   = MAX_US_DEF,
    parameter int unsigned W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    servo_pwm_bank_if.slave   cmd,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start,
    output logic              cmd_clamped,
    output logic              cmd_error
);
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned UCW = $clog2(FRAME_US);
    localparam int unsigned PW  = $clog2(MAX_US + 1);
    localparam logic [PW-1:0] NEUTRAL = PW'((MIN_US + MAX_US) / 2);

    logic [UCW-1:0] us_cnt;
    logic           us_tick;
    logic           boundary;
    logic           tick_unused;

    servo_timebase #(
        .CLK_HZ   (CLK_HZ),
        .FRAME_US (FRAME_US)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .us_cnt   (us_cnt),
        .us_tick  (us_tick),
        .boundary (boundary)
    );

    assign tick_unused = us_tick;

    logic [PW-1:0]     shadow_q [NUM_CH];
    logic [PW-1:0]     shadow_d [NUM_CH];
    logic [PW-1:0]     active_q [NUM_CH];
    logic [PW-1:0]     active_d [NUM_CH];
    logic              run_q, run_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              frame_start_q, frame_start_d;
    logic              clamped_q, clamped_d;
    logic              error_q, error_d;

    logic     xfer;
    logic     ch_ok;
    logic     out_of_range;
    us_word_t us_full;
    logic [PW-1:0] clamped_pw;

    // Writes are refused on the boundary cycle so the shadow-to-active copy sees a stable bank.
    assign cmd.cmd_ready = reset && !boundary;
    assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
    assign ch_ok         = 32'(cmd.cmd_ch) < NUM_CH;
    assign us_full       = us_word_t'(cmd.cmd_us);
    assign out_of_range  = (us_full < MIN_US) || (us_full > MAX_US);
    assign clamped_pw    = PW'(clamp_us(us_full, MIN_US, MAX_US));

    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        run_d         = run_q;
        frame_start_d = boundary;
        clamped_d     = 1'b0;
        error_d       = 1'b0;
        pwm_d         = '0;
        if (boundary) begin
            active_d = shadow_q;
            run_d    = enable;
        end
        if (xfer) begin
            if (ch_ok) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cmd.cmd_ch == CHW'(i)) begin
                        shadow_d[i] = clamped_pw;
                    end
                end
                clamped_d = out_of_range;
            end else begin
                error_d = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = run_q && (us_cnt < UCW'(active_q[i]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= NEUTRAL;
                active_q[i] <= NEUTRAL;
            end
            run_q         <= 1'b0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            clamped_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            run_q         <= run_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            clamped_q     <= clamped_d;
            error_q       <= error_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
    assign cmd_clamped = clamped_q;
    assign cmd_error   = error_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: a frame-level reference model feeds expected pulse widths and
// command flags into queues that a negedge monitor pops and compares against the outputs.
module tb_servo_pwm_bank;
    localparam int CLK_HZ    = 10_000_000;
    localparam int NUM_CH    = 3;
    localparam int FRAME_US  = 200;
    localparam int MIN_US    = 50;
    localparam int MAX_US    = 150;
    localparam int W         = 8;
    localparam int CHW       = 2;
    localparam int DIV       = 10;
    localparam int FRAME_CYC = FRAME_US * DIV;
    localparam int NEUTRAL   = 100;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] pwm_out;
    logic              frame_start;
    logic              cmd_clamped;
    logic              cmd_error;

    servo_pwm_bank_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

    servo_pwm_bank #(
        .CLK_HZ   (CLK_HZ),
        .NUM_CH   (NUM_CH),
        .FRAME_US (FRAME_US),
        .MIN_US   (MIN_US),
        .MAX_US   (MAX_US),
        .W        (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd         (bus),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .cmd_clamped (cmd_clamped),
        .cmd_error   (cmd_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: widths per channel in us, frame timing from a cycle count since release.
    int          cyc_m = 0;
    int          shadow_m [NUM_CH];
    logic [47:0] exp_q [$];
    logic [1:0]  exp_flag_q [$];

    function automatic int clamp_ref(input int us);
        if (us < MIN_US) return MIN_US;
        if (us > MAX_US) return MAX_US;
        return us;
    endfunction

    function automatic logic [47:0] frame_exp(input logic en);
        logic [47:0] f;
        f = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            f[i*16 +: 16] = en ? 16'(shadow_m[i] * DIV) : 16'd0;
        end
        return f;
    endfunction

    function automatic logic m_ready();
        return reset && ((cyc_m % FRAME_CYC) != FRAME_CYC - 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_m <= 0;
            for (int i = 0; i < NUM_CH; i++) shadow_m[i] <= NEUTRAL;
            exp_q.delete();
            exp_q.push_back(48'd0);
            exp_flag_q.delete();
        end else begin
            if ((cyc_m % FRAME_CYC) == FRAME_CYC - 1) begin
                exp_q.push_back(frame_exp(enable));
            end else if (bus.cmd_valid) begin
                if (int'(bus.cmd_ch) < NUM_CH) begin
                    shadow_m[int'(bus.cmd_ch)] <= clamp_ref(int'(bus.cmd_us));
                    exp_flag_q.push_back({(int'(bus.cmd_us) < MIN_US) || (int'(bus.cmd_us) > MAX_US), 1'b0});
                end else begin
                    exp_flag_q.push_back(2'b01);
                end
            end
            cyc_m <= cyc_m + 1;
        end
    end

    // Monitor: measure each frame's high time and pulse count per channel between frame_starts.
    int                hi_cnt [NUM_CH];
    int                rise_cnt [NUM_CH];
    logic [NUM_CH-1:0] pwm_prev;

    task automatic close_frame(input logic [47:0] f);
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("ch%0d_high_cycles", i), 64'(hi_cnt[i]), 64'(f[i*16 +: 16]));
            check($sformatf("ch%0d_pulse_count", i), 64'(rise_cnt[i]),
                  (f[i*16 +: 16] != 16'd0) ? 64'd1 : 64'd0);
        end
    endtask

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hi_cnt[i]   <= 0;
                rise_cnt[i] <= 0;
            end
            pwm_prev <= '0;
        end else begin
            if (exp_flag_q.size() > 0) begin
                check("cmd_flags", 64'({cmd_clamped, cmd_error}), 64'(exp_flag_q.pop_front()));
            end else if (cmd_clamped || cmd_error) begin
                check("spurious_flags", 64'({cmd_clamped, cmd_error}), 64'd0);
            end
            if (frame_start || (cyc_m != 0 && (cyc_m % FRAME_CYC) == 0)) begin
                check("frame_start", 64'(frame_start), 64'(cyc_m != 0 && (cyc_m % FRAME_CYC) == 0));
            end
            if (frame_start) begin
                if (exp_q.size() > 0) begin
                    close_frame(exp_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL frame_queue: got frame_start=1, expected no frame end yet");
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    hi_cnt[i]   <= int'(pwm_out[i]);
                    rise_cnt[i] <= int'(pwm_out[i]);
                end
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    hi_cnt[i]   <= hi_cnt[i] + int'(pwm_out[i]);
                    rise_cnt[i] <= rise_cnt[i] + int'(pwm_out[i] && !pwm_prev[i]);
                end
            end
            pwm_prev <= pwm_out;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while (((cyc_m % FRAME_CYC) != ph) && (n < 2 * FRAME_CYC)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_us(input int u);
        wait_phase(u * DIV);
    endtask

    task automatic send(input int ch, input int us);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = CHW'(ch);
        bus.cmd_us    = W'(us);
        while (!done) begin
            check("cmd_ready", 64'(bus.cmd_ready), 64'(m_ready()));
            done = bus.cmd_ready;
            @(negedge clk);
            tries++;
            if (!done && tries >= 4) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept: got no cmd_ready in %0d cycles, expected acceptance", tries);
                done = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.cmd_us    = '0;
        repeat (50) @(negedge clk);
        check("reset_pwm_out", 64'(pwm_out), 64'd0);
        check("reset_frame_start", 64'(frame_start), 64'd0);
        check("reset_cmd_clamped", 64'(cmd_clamped), 64'd0);
        check("reset_cmd_error", 64'(cmd_error), 64'd0);
        check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);

        enable = 1'b1;
        reset  = 1'b1;
        wait_cycles(FRAME_CYC);

        wait_us(120);
        send(1, 70);

        wait_us(10);
        send(0, 20);
        send(2, 255);
        send(3, 90);

        wait_us(10);
        send(1, 60);
        send(1, 140);

        wait_phase(FRAME_CYC - 1);
        send(0, 80);

        wait_us(30);
        enable = 1'b0;
        wait_cycles(FRAME_CYC);
        wait_us(80);
        enable = 1'b1;
        wait_cycles(FRAME_CYC);
        wait_us(40);
        check("pwm_before_reset", 64'(pwm_out), 64'(3'b111));
        #2 reset = 1'b0;
        #1;
        check("async_reset_pwm_out", 64'(pwm_out), 64'd0);
        check("async_reset_frame_start", 64'(frame_start), 64'd0);
        check("async_reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        wait_cycles(2 * FRAME_CYC + 20);

        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) begin
                wait_cycles($urandom_range(1, 400));
                send($urandom_range(0, 3), $urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            wait_us(5);
        end
        enable = 1'b1;
        wait_cycles(FRAME_CYC);
        wait_us(5);
        wait_cycles(FRAME_CYC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
